// File: rtl/scoreboard_pkg.sv
// Shared pipeline types for the register scoreboard: register address, per-register
// entry struct and the default tag/latency sizing.
package scoreboard_pkg;

  localparam int unsigned SbNtag = 8;
  localparam int unsigned SbLatW = 3;
  localparam int unsigned SbTagW = $clog2(SbNtag);

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic              pending;
    logic [SbLatW-1:0] count;
    logic [SbTagW-1:0] tag;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard slot: load on issue, count down, clear on a tag-matching writeback.
// Flush beats issue, and issue beats writeback.
module sb_entry
  import scoreboard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic [SbLatW-1:0] set_count_i,
  input  logic [SbTagW-1:0] set_tag_i,
  input  logic              wb_i,
  input  logic [SbTagW-1:0] wb_tag_i,
  input  logic              flush_i,
  output sb_entry_t         entry_o
);

  sb_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.pending = 1'b0;
      entry_d.count   = '0;
    end else if (set_i) begin
      entry_d.pending = 1'b1;
      entry_d.count   = set_count_i;
      entry_d.tag     = set_tag_i;
    end else if (entry_q.pending) begin
      // A stale writer's writeback must not release a register a newer writer owns.
      if (wb_i && (entry_q.tag == wb_tag_i)) begin
        entry_d.pending = 1'b0;
        entry_d.count   = '0;
      end else if (entry_q.count != '0) begin
        entry_d.count = entry_q.count - SbLatW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard: tracks in-flight writers per register and flags busy source operands.
// Define SCOREBOARD_STATS_EN to build the 32-bit stall-cycle counter.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned NTAG  = SbNtag,
  parameter int unsigned LAT_W = SbLatW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  creg_addr_t              issue_rd,
  input  logic [LAT_W-1:0]        issue_lat,
  output logic [$clog2(NTAG)-1:0] issue_tag,
  input  logic                    wb_valid,
  input  creg_addr_t              wb_rd,
  input  logic [$clog2(NTAG)-1:0] wb_tag,
  input  logic                    flush,
  input  creg_addr_t              rs1,
  input  creg_addr_t              rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    stall,
  output logic [31:0]             stall_cnt
);

  localparam int unsigned TagW = $clog2(NTAG);

  logic [TagW-1:0]  tag_q;
  logic [LAT_W-1:0] set_count;
  sb_entry_t        entries [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else if (issue_valid) begin
      tag_q <= tag_q + TagW'(1);
    end
  end

  assign issue_tag = tag_q;

  // The issue cycle is the first latency cycle, so the stored countdown is lat-1.
  assign set_count = (issue_lat == '0) ? '0 : issue_lat - LAT_W'(1);

  assign entries[0] = '0;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    sb_entry u_entry (
      .clk_i       (clk),
      .rst_ni      (reset),
      .set_i       (issue_valid && (issue_rd == creg_addr_t'(r))),
      .set_count_i (set_count),
      .set_tag_i   (tag_q),
      .wb_i        (wb_valid && (wb_rd == creg_addr_t'(r))),
      .wb_tag_i    (wb_tag),
      .flush_i     (flush),
      .entry_o     (entries[r])
    );
  end

  always_comb begin
    rs1_busy = entries[rs1].pending && (entries[rs1].count != '0);
    rs2_busy = entries[rs2].pending && (entries[rs2].count != '0);
    stall    = rs1_busy || rs2_busy;
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
